sound_arbiter: RTL and testbench

Arbitrates game-event sound requests (chomp, ghost eaten, death, intro, …) onto the single `sound_type` input of the audio block. It sits between `drawing_logic` game-state logic and `audio`, runs in the 25 MHz pixel domain, and times each sound's length in frames using the VGA frame strobe. Requests use fixed priority with preemption, and each granted sound plays for a per-requester programmed number of frames.

---
 rtl/sound_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sound_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sound_arbiter.sv
// Fixed-priority, preemptive arbiter that turns game-event sound requests into one sound_type for the audio block.
// Define SOUND_ARB_QUEUE_EN to queue lower-priority requests made during playback; by default they are dropped.
module sound_arbiter #(
    parameter int                          NUM_REQ   = 4,
    parameter int                          DUR_W     = 8,
    parameter logic [NUM_REQ*DUR_W-1:0]    DURATIONS = {8'd60, 8'd30, 8'd10, 8'd4},
    parameter int                          SOUND_W   = $clog2(NUM_REQ+1)
) (
    input  logic               vga_pix_clk,
    input  logic               rst,
    input  logic               frame_stb,
    input  logic [NUM_REQ-1:0] req,
    output logic [SOUND_W-1:0] sound_type,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PLAY = 1'b1;

    // Programmed length of requester idx; a zero entry still plays for one frame.
    function automatic logic [DUR_W-1:0] dur_of(input logic [IDX_W-1:0] idx);
        logic [DUR_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                d = DURATIONS[i*DUR_W +: DUR_W];
            end
        end
        if (d == '0) begin
            d = DUR_W'(1);
        end
        return d;
    endfunction

    // Index of the lowest set bit, i.e. the highest-priority requester present.
    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    logic               state;
    logic [IDX_W-1:0]   cur;
    logic [DUR_W-1:0]   cnt;
    logic [NUM_REQ-1:0] pend;

    logic               state_n;
    logic [IDX_W-1:0]   cur_n;
    logic [DUR_W-1:0]   cnt_n;
    logic [NUM_REQ-1:0] pend_n;
    logic [SOUND_W-1:0] sound_n;
    logic [NUM_REQ-1:0] grant_n;
    logic               busy_n;

    logic [NUM_REQ-1:0] act;
    logic [NUM_REQ-1:0] rest;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   best_rest;
    logic               do_start;
    logic [IDX_W-1:0]   start_idx;

    assign act       = req | pend;
    assign cand      = lowest(act);
    assign rest      = act & ~onehot(cur);
    assign best_rest = lowest(rest);

    always_comb begin
        state_n   = state;
        cur_n     = cur;
        cnt_n     = cnt;
        sound_n   = sound_type;
        grant_n   = '0;
        busy_n    = busy;
        do_start  = 1'b0;
        start_idx = cand;

        case (state)
            ST_IDLE: begin
                if (|act) begin
                    do_start = 1'b1;
                end
            end
            default: begin
                if ((|act) && (cand < cur)) begin
                    do_start = 1'b1;
                end else if (req[cur]) begin
                    cnt_n   = dur_of(cur);
                    grant_n = onehot(cur);
                end else if (frame_stb) begin
                    if (cnt <= DUR_W'(1)) begin
                        // Hand straight over to the next waiting sound so the audio never drops to silence.
                        if (|rest) begin
                            do_start  = 1'b1;
                            start_idx = best_rest;
                        end else begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                            sound_n = '0;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt - DUR_W'(1);
                    end
                end
            end
        endcase

        // A fresh start always loads the full duration, even if a frame strobe coincides.
        if (do_start) begin
            state_n = ST_PLAY;
            cur_n   = start_idx;
            cnt_n   = dur_of(start_idx);
            grant_n = onehot(start_idx);
            sound_n = SOUND_W'(start_idx) + SOUND_W'(1);
            busy_n  = 1'b1;
        end
    end

`ifdef SOUND_ARB_QUEUE_EN
    // Anything requested but not granted this cycle waits; repeats collapse into one bit.
    assign pend_n = (pend | req) & ~grant_n;
`else
    assign pend_n = '0;
`endif

    always_ff @(posedge vga_pix_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur        <= '0;
            cnt        <= '0;
            pend       <= '0;
            sound_type <= '0;
            grant      <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            cnt        <= cnt_n;
            pend       <= pend_n;
            sound_type <= sound_n;
            grant      <= grant_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboard bench for sound_arbiter: directed stimulus queues expected output events, a monitor checks them.
module tb_sound_arbiter;

    logic       vga_pix_clk = 1'b0;
    logic       rst         = 1'b0;
    logic       frame_stb   = 1'b0;
    logic [3:0] req         = 4'b0000;
    logic [2:0] sound_type;
    logic [3:0] grant;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct packed {
        int         cyc;
        logic [3:0] grant;
        logic [2:0] sound;
    } exp_t;

    exp_t exp_q[$];

    sound_arbiter #(
        .NUM_REQ   (4),
        .DUR_W     (8),
        .DURATIONS ({8'd1, 8'd5, 8'd3, 8'd2}),
        .SOUND_W   (3)
    ) dut (
        .vga_pix_clk (vga_pix_clk),
        .rst         (rst),
        .frame_stb   (frame_stb),
        .req         (req),
        .sound_type  (sound_type),
        .grant       (grant),
        .busy        (busy)
    );

    always #5 vga_pix_clk = ~vga_pix_clk;

    initial forever begin
        @(posedge vga_pix_clk);
        cyc = cyc + 1;
    end

    // Monitor: every grant pulse or sound change must match the next queued expectation.
    initial begin
        logic [2:0] prev_sound;
        exp_t       e;
        prev_sound = 3'd0;
        forever begin
            @(negedge vga_pix_clk);
            if (grant != 4'b0000 || sound_type != prev_sound) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_event cyc=%0d grant=%b sound=%0d busy=%b (no event expected)",
                             cyc, grant, sound_type, busy);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.grant != grant || e.sound != sound_type ||
                        busy != (e.sound != 3'd0)) begin
                        errors = errors + 1;
                        $display("FAIL event got cyc=%0d grant=%b sound=%0d busy=%b, want cyc=%0d grant=%b sound=%0d busy=%b",
                                 cyc, grant, sound_type, busy, e.cyc, e.grant, e.sound, (e.sound != 3'd0));
                    end
                end
            end
            prev_sound = sound_type;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d time limit reached", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic expect_ev(input int c, input logic [3:0] g, input logic [2:0] s);
        exp_q.push_back('{cyc: c, grant: g, sound: s});
    endtask

    task automatic step(input logic [3:0] r, input logic s);
        req       = r;
        frame_stb = s;
        @(negedge vga_pix_clk);
        req       = 4'b0000;
        frame_stb = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(4'b0000, 1'b1);
            step(4'b0000, 1'b0);
        end
    endtask

    task automatic last_frame();
        expect_ev(cyc + 1, 4'b0000, 3'd0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0);
    endtask

    initial begin
        // Reset held with all requests asserted
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_pix_clk);
            chk("reset_sound", {5'd0, sound_type}, 8'd0);
            chk("reset_grant", {4'd0, grant}, 8'd0);
            chk("reset_busy", {7'd0, busy}, 8'd0);
        end
        rst = 1'b0;
        req = 4'b0000;
        idle(2);

        // Single sound: req2 lasts 5 frames
        expect_ev(cyc + 1, 4'b0100, 3'd3);
        step(4'b0100, 1'b0);
        frames(4);
        last_frame();
        idle(3);

        // Preemption: req0 replaces req2, which never resumes
        expect_ev(cyc + 1, 4'b0100, 3'd3);
        step(4'b0100, 1'b0);
        frames(2);
        expect_ev(cyc + 1, 4'b0001, 3'd1);
        step(4'b0001, 1'b0);
        frames(1);
        last_frame();
        idle(6);

        // Lower-priority requests during req1
        expect_ev(cyc + 1, 4'b0010, 3'd2);
        step(4'b0010, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b1000, 1'b0);
        frames(2);
`ifdef SOUND_ARB_QUEUE_EN
        expect_ev(cyc + 1, 4'b1000, 3'd4);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        last_frame();
`else
        last_frame();
`endif
        idle(4);

        // Retrigger restarts the full 3-frame length
        expect_ev(cyc + 1, 4'b0010, 3'd2);
        step(4'b0010, 1'b0);
        frames(2);
        expect_ev(cyc + 1, 4'b0010, 3'd2);
        step(4'b0010, 1'b0);
        frames(2);
        last_frame();
        idle(3);

        // Preempt coinciding with a frame strobe: strobe not counted against new sound
        expect_ev(cyc + 1, 4'b0100, 3'd3);
        step(4'b0100, 1'b0);
        frames(1);
        expect_ev(cyc + 1, 4'b0001, 3'd1);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b0);
        frames(1);
        last_frame();
        idle(3);

        // Simultaneous req1 and req3: lowest index wins
        expect_ev(cyc + 1, 4'b0010, 3'd2);
        step(4'b1010, 1'b0);
        frames(2);
`ifdef SOUND_ARB_QUEUE_EN
        expect_ev(cyc + 1, 4'b1000, 3'd4);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        last_frame();
`else
        last_frame();
`endif
        idle(3);

        // New request present at expiry starts without a silent gap
        expect_ev(cyc + 1, 4'b0010, 3'd2);
        step(4'b0010, 1'b0);
        frames(2);
        expect_ev(cyc + 1, 4'b1000, 3'd4);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b0);
        last_frame();
        idle(3);

        // Asynchronous reset mid-sound clears everything, including pending requests
        expect_ev(cyc + 1, 4'b0100, 3'd3);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        expect_ev(cyc + 1, 4'b0000, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sound", {5'd0, sound_type}, 8'd0);
        chk("async_rst_busy", {7'd0, busy}, 8'd0);
        chk("async_rst_grant", {4'd0, grant}, 8'd0);
        @(negedge vga_pix_clk);
        @(negedge vga_pix_clk);
        rst = 1'b0;
        frames(6);
        chk("post_rst_sound", {5'd0, sound_type}, 8'd0);
        chk("post_rst_busy", {7'd0, busy}, 8'd0);

        idle(3);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL missing_events got=0 remaining, want=%0d events still queued", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
